// File: rtl/reservation_station.sv
// Purpose : age-ordered compacting reservation station; operands wait for tag wakeups, then issue to one FU.
// Latency : an entry allocated ready can issue the cycle after the alloc edge; a woken operand issues the cycle after the wakeup edge.
// Backpr. : alloc_ready = occupancy < DEPTH (a same-cycle issue gives no credit); issue only when fu_is_available.
// Ports   : clk/reset (async, active-high); alloc_* allocation request (valid/ready);
//           wakeup_* result broadcast; fu_is_available/fu_write_enable/fu_* issue port; occupancy count.
module reservation_station #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alloc_valid,
   output logic        alloc_ready,
   input  logic [3:0]  alloc_ALUControl,
   input  logic        alloc_ALUSrc,
   input  logic        alloc_is_for_lsq,
   input  logic [31:0] alloc_imm,
   input  logic        alloc_rs1_ready,
   input  logic        alloc_rs2_ready,
   input  logic [5:0]  alloc_rs1_tag,
   input  logic [5:0]  alloc_rs2_tag,
   input  logic [31:0] alloc_rs1_value,
   input  logic [31:0] alloc_rs2_value,
   input  logic [5:0]  alloc_dest_tag,
   input  logic [5:0]  alloc_rob_index,
   input  logic        wakeup_active,
   input  logic [5:0]  wakeup_tag,
   input  logic [31:0] wakeup_value,
   input  logic        fu_is_available,
   output logic        fu_write_enable,
   output logic [3:0]  fu_ALUControl,
   output logic        fu_ALUSrc,
   output logic        fu_is_for_lsq,
   output logic [31:0] fu_imm,
   output logic [31:0] fu_rs1_value,
   output logic [31:0] fu_rs2_value,
   output logic [5:0]  fu_tag_to_output,
   output logic [5:0]  fu_rob_index,
   output logic [4:0]  occupancy
);

   typedef struct packed {
      logic        valid;
      logic [3:0]  alu_ctrl;
      logic        alu_src;
      logic        is_lsq;
      logic [31:0] imm;
      logic        rs1_rdy;
      logic [5:0]  rs1_tag;
      logic [31:0] rs1_val;
      logic        rs2_rdy;
      logic [5:0]  rs2_tag;
      logic [31:0] rs2_val;
      logic [5:0]  dest_tag;
      logic [5:0]  rob_idx;
   } entry_t;

   localparam logic [4:0] DEPTH_W = 5'(DEPTH);

   entry_t            ent_q [DEPTH];
   entry_t            ent_d [DEPTH];
   entry_t            ent_up [DEPTH];   // entry one slot younger, '0 above the top
   entry_t            new_ent;
   entry_t            nxt;
   entry_t            sel;
   logic [4:0]        occ_q, occ_d;
   logic [DEPTH-1:0]  issuable;
   logic              issue_found;
   logic [4:0]        issue_idx;
   logic              issue_fire;
   logic              alloc_fire;
   logic [4:0]        alloc_idx;
   logic              new_wake1, new_wake2;

   for (genvar g = 0; g < DEPTH; g++) begin : g_up
      if (g < DEPTH - 1) begin : g_mid
         assign ent_up[g] = ent_q[g+1];
      end else begin : g_top
         assign ent_up[g] = '0;
      end
   end

   always_comb begin
      issuable = '0;
      for (int i = 0; i < DEPTH; i++) begin
         issuable[i] = ent_q[i].valid && ent_q[i].rs1_rdy && (ent_q[i].rs2_rdy || ent_q[i].alu_src);
      end
   end

   // Scan from the top so the lowest (oldest) issuable index wins.
   always_comb begin
      issue_found = 1'b0;
      issue_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (issuable[i]) begin
            issue_found = 1'b1;
            issue_idx   = 5'(i);
         end
      end
   end

   assign alloc_ready     = (occ_q < DEPTH_W);
   assign issue_fire      = fu_is_available && issue_found;
   assign fu_write_enable = issue_fire;
   assign alloc_fire      = alloc_valid && alloc_ready;
   // The slot the new entry lands in shifts down with a same-cycle issue.
   assign alloc_idx       = occ_q - {4'b0, issue_fire};
   assign occ_d           = occ_q + {4'b0, alloc_fire} - {4'b0, issue_fire};
   assign occupancy       = occ_q;

   // Issue mux; all fields read as zero when nothing issues.
   always_comb begin
      sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (issue_fire && issue_idx == 5'(i)) sel = ent_q[i];
      end
   end

   assign fu_ALUControl    = sel.alu_ctrl;
   assign fu_ALUSrc        = sel.alu_src;
   assign fu_is_for_lsq    = sel.is_lsq;
   assign fu_imm           = sel.imm;
   assign fu_rs1_value     = sel.rs1_val;
   assign fu_rs2_value     = sel.rs2_val;
   assign fu_tag_to_output = sel.dest_tag;
   assign fu_rob_index     = sel.rob_idx;

   // Incoming entry, with a same-cycle broadcast bypassed into it.
   assign new_wake1 = wakeup_active && !alloc_rs1_ready && (alloc_rs1_tag == wakeup_tag);
   assign new_wake2 = wakeup_active && !alloc_rs2_ready && (alloc_rs2_tag == wakeup_tag);

   always_comb begin
      new_ent          = '0;
      new_ent.valid    = 1'b1;
      new_ent.alu_ctrl = alloc_ALUControl;
      new_ent.alu_src  = alloc_ALUSrc;
      new_ent.is_lsq   = alloc_is_for_lsq;
      new_ent.imm      = alloc_imm;
      new_ent.rs1_rdy  = alloc_rs1_ready || new_wake1;
      new_ent.rs1_tag  = alloc_rs1_tag;
      new_ent.rs1_val  = new_wake1 ? wakeup_value : alloc_rs1_value;
      new_ent.rs2_rdy  = alloc_rs2_ready || new_wake2;
      new_ent.rs2_tag  = alloc_rs2_tag;
      new_ent.rs2_val  = new_wake2 ? wakeup_value : alloc_rs2_value;
      new_ent.dest_tag = alloc_dest_tag;
      new_ent.rob_idx  = alloc_rob_index;
   end

   // Next state: compact over the issued slot, apply wakeup to the shifted
   // contents so captured values travel with their entry, then insert.
   always_comb begin
      nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (issue_fire && 5'(i) >= issue_idx) nxt = ent_up[i];
         else                                  nxt = ent_q[i];
         if (wakeup_active && nxt.valid && !nxt.rs1_rdy && nxt.rs1_tag == wakeup_tag) begin
            nxt.rs1_rdy = 1'b1;
            nxt.rs1_val = wakeup_value;
         end
         if (wakeup_active && nxt.valid && !nxt.rs2_rdy && nxt.rs2_tag == wakeup_tag) begin
            nxt.rs2_rdy = 1'b1;
            nxt.rs2_val = wakeup_value;
         end
         if (alloc_fire && alloc_idx == 5'(i)) nxt = new_ent;
         ent_d[i] = nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         occ_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
         occ_q <= occ_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (occ_d <= DEPTH_W)
            else $fatal(1, "reservation_station: occupancy would exceed DEPTH");
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// Purpose : directed scoreboard bench for reservation_station.
// Latency : issue checked on the falling edge of the cycle it is presented.
// Backpr. : fu_is_available toggled by the stimulus to hold and release issue.
module tb_reservation_station;

   localparam int DEPTH = 8;

   logic        clk;
   logic        reset;
   logic        alloc_valid;
   logic        alloc_ready;
   logic [3:0]  alloc_ALUControl;
   logic        alloc_ALUSrc;
   logic        alloc_is_for_lsq;
   logic [31:0] alloc_imm;
   logic        alloc_rs1_ready, alloc_rs2_ready;
   logic [5:0]  alloc_rs1_tag, alloc_rs2_tag;
   logic [31:0] alloc_rs1_value, alloc_rs2_value;
   logic [5:0]  alloc_dest_tag, alloc_rob_index;
   logic        wakeup_active;
   logic [5:0]  wakeup_tag;
   logic [31:0] wakeup_value;
   logic        fu_is_available;
   logic        fu_write_enable;
   logic [3:0]  fu_ALUControl;
   logic        fu_ALUSrc;
   logic        fu_is_for_lsq;
   logic [31:0] fu_imm;
   logic [31:0] fu_rs1_value, fu_rs2_value;
   logic [5:0]  fu_tag_to_output, fu_rob_index;
   logic [4:0]  occupancy;

   reservation_station #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_ALUControl(alloc_ALUControl), .alloc_ALUSrc(alloc_ALUSrc),
      .alloc_is_for_lsq(alloc_is_for_lsq), .alloc_imm(alloc_imm),
      .alloc_rs1_ready(alloc_rs1_ready), .alloc_rs2_ready(alloc_rs2_ready),
      .alloc_rs1_tag(alloc_rs1_tag), .alloc_rs2_tag(alloc_rs2_tag),
      .alloc_rs1_value(alloc_rs1_value), .alloc_rs2_value(alloc_rs2_value),
      .alloc_dest_tag(alloc_dest_tag), .alloc_rob_index(alloc_rob_index),
      .wakeup_active(wakeup_active), .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
      .fu_is_available(fu_is_available), .fu_write_enable(fu_write_enable),
      .fu_ALUControl(fu_ALUControl), .fu_ALUSrc(fu_ALUSrc), .fu_is_for_lsq(fu_is_for_lsq),
      .fu_imm(fu_imm), .fu_rs1_value(fu_rs1_value), .fu_rs2_value(fu_rs2_value),
      .fu_tag_to_output(fu_tag_to_output), .fu_rob_index(fu_rob_index),
      .occupancy(occupancy)
   );

   typedef struct {
      logic [3:0]  ctrl;
      logic        src;
      logic        lsq;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [5:0]  tag;
      logic [5:0]  rob;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input logic [3:0] ctrl, input logic src, input logic lsq,
                           input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [5:0] tag, input logic [5:0] rob);
      exp_t e;
      e.ctrl = ctrl; e.src = src; e.lsq = lsq; e.imm = imm;
      e.rs1 = rs1; e.rs2 = rs2; e.tag = tag; e.rob = rob;
      sb.push_back(e);
   endtask

   task automatic drive_alloc(input logic [3:0] ctrl, input logic src, input logic lsq,
                              input logic [31:0] imm,
                              input logic r1rdy, input logic [5:0] t1, input logic [31:0] v1,
                              input logic r2rdy, input logic [5:0] t2, input logic [31:0] v2,
                              input logic [5:0] dest, input logic [5:0] rob);
      alloc_valid      = 1'b1;
      alloc_ALUControl = ctrl;
      alloc_ALUSrc     = src;
      alloc_is_for_lsq = lsq;
      alloc_imm        = imm;
      alloc_rs1_ready  = r1rdy; alloc_rs1_tag = t1; alloc_rs1_value = v1;
      alloc_rs2_ready  = r2rdy; alloc_rs2_tag = t2; alloc_rs2_value = v2;
      alloc_dest_tag   = dest;
      alloc_rob_index  = rob;
   endtask

   task automatic wake(input logic [5:0] tag, input logic [31:0] val);
      wakeup_active = 1'b1;
      wakeup_tag    = tag;
      wakeup_value  = val;
   endtask

   // Advance past the next rising edge; one-shot strobes drop afterwards.
   task automatic cyc();
      @(posedge clk);
      #1;
      alloc_valid   = 1'b0;
      wakeup_active = 1'b0;
   endtask

   // Scoreboard monitor: every issue presented must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && fu_write_enable) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_issue actual tag=%0d required no issue at t=%0t",
                     fu_tag_to_output, $time);
         end else begin
            mon_e = sb.pop_front();
            chk("fu_ALUControl",    32'(fu_ALUControl),    32'(mon_e.ctrl));
            chk("fu_ALUSrc",        32'(fu_ALUSrc),        32'(mon_e.src));
            chk("fu_is_for_lsq",    32'(fu_is_for_lsq),    32'(mon_e.lsq));
            chk("fu_imm",           fu_imm,                mon_e.imm);
            chk("fu_rs1_value",     fu_rs1_value,          mon_e.rs1);
            if (!mon_e.src) chk("fu_rs2_value", fu_rs2_value, mon_e.rs2);
            chk("fu_tag_to_output", 32'(fu_tag_to_output), 32'(mon_e.tag));
            chk("fu_rob_index",     32'(fu_rob_index),     32'(mon_e.rob));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      alloc_valid = 1'b0; alloc_ALUControl = '0; alloc_ALUSrc = 1'b0; alloc_is_for_lsq = 1'b0;
      alloc_imm = '0; alloc_rs1_ready = 1'b0; alloc_rs2_ready = 1'b0;
      alloc_rs1_tag = '0; alloc_rs2_tag = '0; alloc_rs1_value = '0; alloc_rs2_value = '0;
      alloc_dest_tag = '0; alloc_rob_index = '0;
      wakeup_active = 1'b0; wakeup_tag = '0; wakeup_value = '0;
      fu_is_available = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_occupancy",   32'(occupancy),        32'd0);
      chk("rst_alloc_ready", 32'(alloc_ready),      32'd1);
      chk("rst_fu_we",       32'(fu_write_enable),  32'd0);
      chk("rst_fu_rs1",      fu_rs1_value,          32'd0);
      chk("rst_fu_tag",      32'(fu_tag_to_output), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // ADD, rs1 ready, imm operand
      push_exp(4'h2, 1'b1, 1'b0, 32'd7, 32'd5, 32'd0, 6'd3, 6'd1);
      drive_alloc(4'h2, 1'b1, 1'b0, 32'd7, 1'b1, 6'd0, 32'd5, 1'b0, 6'd0, 32'd0, 6'd3, 6'd1);
      @(negedge clk);
      chk("t1_pre_we", 32'(fu_write_enable), 32'd0);
      cyc();
      @(negedge clk);
      chk("t1_we", 32'(fu_write_enable), 32'd1);
      chk("t1_occ_1", 32'(occupancy), 32'd1);
      cyc();
      @(negedge clk);
      chk("t1_occ_0", 32'(occupancy), 32'd0);
      chk("t1_idle_tag_zero", 32'(fu_tag_to_output), 32'd0);
      chk("t1_idle_imm_zero", fu_imm, 32'd0);

      // OR waiting on tag 9, woken two cycles later
      cyc();
      push_exp(4'h3, 1'b1, 1'b0, 32'h0F, 32'hF0, 32'd0, 6'd10, 6'd2);
      drive_alloc(4'h3, 1'b1, 1'b0, 32'h0F, 1'b0, 6'd9, 32'd0, 1'b0, 6'd0, 32'd0, 6'd10, 6'd2);
      cyc();
      @(negedge clk);
      chk("t2_wait_we", 32'(fu_write_enable), 32'd0);
      cyc();
      wake(6'd9, 32'hF0);
      @(negedge clk);
      chk("t2_no_comb_wake", 32'(fu_write_enable), 32'd0);
      cyc();
      @(negedge clk);
      chk("t2_issue_after_wake", 32'(fu_write_enable), 32'd1);
      cyc();
      @(negedge clk);
      chk("t2_occ_0", 32'(occupancy), 32'd0);

      // Younger ready entry overtakes an older waiting one
      cyc();
      push_exp(4'h4, 1'b0, 1'b0, 32'h0, 32'h11, 32'h33, 6'd21, 6'd6);
      push_exp(4'h1, 1'b0, 1'b1, 32'h5, 32'h44, 32'h22, 6'd20, 6'd5);
      drive_alloc(4'h1, 1'b0, 1'b1, 32'h5, 1'b0, 6'd4, 32'd0, 1'b1, 6'd0, 32'h22, 6'd20, 6'd5);
      cyc();
      drive_alloc(4'h4, 1'b0, 1'b0, 32'h0, 1'b1, 6'd0, 32'h11, 1'b1, 6'd0, 32'h33, 6'd21, 6'd6);
      @(negedge clk);
      chk("t3_a_blocked", 32'(fu_write_enable), 32'd0);
      cyc();
      wake(6'd4, 32'h44);
      @(negedge clk);
      chk("t3_b_issues", 32'(fu_write_enable), 32'd1);
      chk("t3_occ_2", 32'(occupancy), 32'd2);
      cyc();
      @(negedge clk);
      chk("t3_a_issues", 32'(fu_write_enable), 32'd1);
      chk("t3_occ_1", 32'(occupancy), 32'd1);
      cyc();
      @(negedge clk);
      chk("t3_occ_0", 32'(occupancy), 32'd0);

      // Fill to DEPTH, overflow attempts, then drain in age order
      cyc();
      fu_is_available = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         push_exp(4'(i), 1'b0, 1'(i & 1), 32'(32'h1000 + i), 32'(32'h100 + i),
                  32'(32'h200 + i), 6'(30 + i), 6'(i));
         drive_alloc(4'(i), 1'b0, 1'(i & 1), 32'(32'h1000 + i), 1'b1, 6'd0, 32'(32'h100 + i),
                     1'b1, 6'd0, 32'(32'h200 + i), 6'(30 + i), 6'(i));
         cyc();
      end
      drive_alloc(4'hF, 1'b1, 1'b0, 32'hBAD, 1'b1, 6'd0, 32'hBAD, 1'b1, 6'd0, 32'hBAD, 6'd63, 6'd63);
      @(negedge clk);
      chk("t4_full_occ", 32'(occupancy), 32'(DEPTH));
      chk("t4_full_ready", 32'(alloc_ready), 32'd0);
      chk("t4_held_we", 32'(fu_write_enable), 32'd0);
      cyc();
      drive_alloc(4'hE, 1'b1, 1'b0, 32'hBAD, 1'b1, 6'd0, 32'hBAD, 1'b1, 6'd0, 32'hBAD, 6'd62, 6'd62);
      fu_is_available = 1'b1;
      @(negedge clk);
      chk("t4_ignored_occ", 32'(occupancy), 32'(DEPTH));
      chk("t4_no_credit", 32'(alloc_ready), 32'd0);
      chk("t4_drain_we", 32'(fu_write_enable), 32'd1);
      cyc();
      @(negedge clk);
      chk("t4_after_first_occ", 32'(occupancy), 32'(DEPTH - 1));
      chk("t4_after_first_ready", 32'(alloc_ready), 32'd1);
      repeat (DEPTH - 1) cyc();
      @(negedge clk);
      chk("t4_drained_occ", 32'(occupancy), 32'd0);

      // Alloc+issue at occupancy 1, with alloc bypass of a wakeup on rs2
      cyc();
      fu_is_available = 1'b0;
      push_exp(4'h5, 1'b1, 1'b0, 32'h55, 32'h66, 32'd0, 6'd40, 6'd7);
      push_exp(4'h6, 1'b0, 1'b0, 32'h0, 32'h77, 32'h80000000, 6'd41, 6'd8);
      drive_alloc(4'h5, 1'b1, 1'b0, 32'h55, 1'b1, 6'd0, 32'h66, 1'b0, 6'd0, 32'd0, 6'd40, 6'd7);
      cyc();
      fu_is_available = 1'b1;
      drive_alloc(4'h6, 1'b0, 1'b0, 32'h0, 1'b1, 6'd0, 32'h77, 1'b0, 6'd12, 32'd0, 6'd41, 6'd8);
      wake(6'd12, 32'h80000000);
      @(negedge clk);
      chk("t5_x_issues", 32'(fu_write_enable), 32'd1);
      cyc();
      @(negedge clk);
      chk("t5_occ_1", 32'(occupancy), 32'd1);
      chk("t5_y_issues", 32'(fu_write_enable), 32'd1);
      cyc();
      @(negedge clk);
      chk("t5_occ_0", 32'(occupancy), 32'd0);

      // Non-matching wakeup, then tag 0 wakes both operands while shifting
      cyc();
      fu_is_available = 1'b0;
      push_exp(4'h7, 1'b0, 1'b0, 32'h0, 32'h1, 32'h2, 6'd50, 6'd9);
      push_exp(4'h8, 1'b0, 1'b1, 32'h99, 32'hABCD, 32'hABCD, 6'd51, 6'd10);
      drive_alloc(4'h7, 1'b0, 1'b0, 32'h0, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2, 6'd50, 6'd9);
      cyc();
      drive_alloc(4'h8, 1'b0, 1'b1, 32'h99, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 6'd51, 6'd10);
      cyc();
      wake(6'd33, 32'hDEAD);
      cyc();
      fu_is_available = 1'b1;
      wake(6'd0, 32'hABCD);
      @(negedge clk);
      chk("t6_occ_2", 32'(occupancy), 32'd2);
      chk("t6_p_issues", 32'(fu_write_enable), 32'd1);
      cyc();
      @(negedge clk);
      chk("t6_q_issues", 32'(fu_write_enable), 32'd1);
      cyc();
      @(negedge clk);
      chk("t6_occ_0", 32'(occupancy), 32'd0);

      // Asynchronous reset with 3 pending entries
      cyc();
      fu_is_available = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_alloc(4'h9, 1'b0, 1'b0, 32'h0, 1'b1, 6'd0, 32'h5A, 1'b1, 6'd0, 32'hA5, 6'(55 + i), 6'(20 + i));
         cyc();
      end
      @(negedge clk);
      chk("t7_occ_3", 32'(occupancy), 32'd3);
      cyc();
      reset = 1'b1;
      fu_is_available = 1'b1;
      #1;
      chk("t7_async_occ", 32'(occupancy), 32'd0);
      chk("t7_async_we", 32'(fu_write_enable), 32'd0);
      chk("t7_async_ready", 32'(alloc_ready), 32'd1);
      @(negedge clk);
      chk("t7_hold_we", 32'(fu_write_enable), 32'd0);
      chk("t7_hold_rs1", fu_rs1_value, 32'd0);
      cyc();
      cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("t7_no_stale_we", 32'(fu_write_enable), 32'd0);
      chk("t7_post_occ", 32'(occupancy), 32'd0);
      cyc();
      push_exp(4'hA, 1'b0, 1'b1, 32'h3C, 32'h123, 32'h456, 6'd1, 6'd2);
      drive_alloc(4'hA, 1'b0, 1'b1, 32'h3C, 1'b1, 6'd0, 32'h123, 1'b1, 6'd0, 32'h456, 6'd1, 6'd2);
      cyc();
      @(negedge clk);
      chk("t7_first_alloc_occ", 32'(occupancy), 32'd1);
      chk("t7_first_alloc_we", 32'(fu_write_enable), 32'd1);
      cyc();
      @(negedge clk);
      chk("t7_final_occ", 32'(occupancy), 32'd0);

      cyc();
      @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: number of entries, 2..16.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 alloc_valid  input  1  dispatch presents an instruction this cycle.
REQ-005 alloc_ready  output  1  an entry is free; an allocation is accepted when alloc_valid && alloc_ready.
REQ-006 alloc_ALUControl  input  4  operation code; alloc_ALUSrc  input  1  1 selects imm as the RHS operand.
REQ-007 alloc_is_for_lsq  input  1  passed through to the functional unit unchanged.
REQ-008 alloc_imm  input  32  immediate operand.
REQ-009 alloc_rs1_ready, alloc_rs2_ready  input  1 each  operand value already valid.
REQ-010 alloc_rs1_tag, alloc_rs2_tag  input  6 each  producer tag when the matching ready bit is 0.
REQ-011 alloc_rs1_value, alloc_rs2_value  input  32 each  operand value when the matching ready bit is 1.
REQ-012 alloc_dest_tag, alloc_rob_index  input  6 each  destination tag and ROB slot.
REQ-013 wakeup_active  input  1  result broadcast valid; wakeup_tag  input  6  broadcast tag; wakeup_value  input  32  broadcast value.
REQ-014 fu_is_available  input  1  functional unit accepts an operation this cycle.
REQ-015 fu_write_enable  output  1  issue strobe to the functional unit.
REQ-016 fu_ALUControl 4, fu_ALUSrc 1, fu_is_for_lsq 1, fu_imm 32, fu_rs1_value 32, fu_rs2_value 32, fu_tag_to_output 6, fu_rob_index 6  outputs  fields of the issued entry.
REQ-017 occupancy  output  5  number of valid entries.

Function
REQ-018 Entries SHALL form a compacting queue ordered by age, with index 0 the oldest.
REQ-019 An entry SHALL be issuable when valid, rs1 is ready, and either rs2 is ready or ALUSrc=1.
REQ-020 fu_write_enable SHALL be combinational: it is 1 iff fu_is_available=1 and at least one entry is issuable.
REQ-021 The issued entry SHALL be the lowest-index issuable entry.
REQ-022 When fu_write_enable=1, the fu_* outputs SHALL carry that entry's fields: tag_to_output = dest_tag, and rs2_value = the stored value (content is don't-care when ALUSrc=1).
REQ-023 When fu_write_enable=0, all fu_* data outputs SHALL be 0.
REQ-024 On issue, the issued entry SHALL be removed and every younger entry shifted down one index on the same clock edge, preserving order.
REQ-025 On allocation, the new entry SHALL be written at index (occupancy minus 1 if an issue happens this cycle, else occupancy).
REQ-026 alloc_ready SHALL equal occupancy < DEPTH, with no credit for a same-cycle issue.
REQ-027 An allocation with alloc_valid=1 and alloc_ready=0 SHALL be ignored, with no state change from it.
REQ-028 On wakeup_active=1, every valid entry with a not-ready operand whose tag equals wakeup_tag SHALL capture wakeup_value and set that operand ready at the edge.
REQ-029 Both operands of a single entry SHALL be woken by the same broadcast when both tags match.
REQ-030 Wakeup SHALL also apply to the entry being allocated in the same cycle (alloc bypass).
REQ-031 Wakeup SHALL apply to entries shifted in the same cycle; captured values follow the shift.
REQ-032 An operand woken at edge N SHALL be issuable no earlier than the cycle after edge N; there is no combinational wakeup-to-issue path.
REQ-033 A wakeup matching no entry SHALL have no effect.
REQ-034 Tag 0 carries no special meaning.
REQ-035 occupancy SHALL update at each edge by +1 on accepted allocation, -1 on issue, and 0 when both occur.
REQ-036 Simultaneous allocate and issue at DEPTH full SHALL leave the allocation rejected.
REQ-037 Simultaneous allocate and issue at occupancy 1 SHALL leave the new entry at index 0.
REQ-038 The block SHALL stop with $fatal if occupancy would exceed DEPTH.

Reset
REQ-039 While reset=1, all entries SHALL be invalid, occupancy=0, alloc_ready=1, fu_write_enable=0, and all fu_* outputs 0.
REQ-040 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge, and no issue SHALL occur while reset is held.
REQ-041 The first accepted allocation after reset deassertion SHALL land at index 0.

Verification
REQ-042 Allocate ADD with rs1=5 ready, imm=7, ALUSrc=1, dest 3, fu_is_available=1 -> next cycle fu_write_enable=1, fu_rs1_value=5, fu_imm=7, fu_tag_to_output=3; following cycle occupancy=0.
REQ-043 Allocate OR with rs1 waiting on tag 9, then wakeup tag 9 value 0xF0 two cycles later -> capture at that edge, issue exactly one cycle after it, fu_rs1_value=0xF0.
REQ-044 Allocate entry A waiting on tag 4, then entry B fully ready, fu_is_available=1 -> B issues first; after wakeup tag 4, A issues and occupancy returns to 0.
REQ-045 Fill DEPTH entries with fu_is_available=0 -> alloc_ready=0; one more alloc_valid is ignored; raise fu_is_available -> entries issue in age order, one per cycle, and alloc_ready returns to 1 after the first issue.
REQ-046 Allocate with rs2 tag 12 in the same cycle as wakeup tag 12 value 0x80000000 -> the entry stores rs2 ready with 0x80000000 and is issuable the next cycle.
REQ-047 Assert reset with 3 valid entries, fu_is_available=1 -> fu_write_enable=0 immediately and occupancy=0; after release no stale issue occurs.
